// File: rtl/sync_descrambler_pkg.sv
// Shared types and the LFSR step function for the self-synchronising descrambler.
package sync_descrambler_pkg;

    localparam int unsigned LFSR_MAX_W = 64;

    typedef logic [LFSR_MAX_W-1:0] lfsr_wide_t;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // One keystream step; s and poly are zero-extended from 'width' bits.
    function automatic lfsr_wide_t lfsr_next(input lfsr_wide_t s,
                                             input lfsr_wide_t poly,
                                             input int unsigned width);
        logic fb;
        fb = (^(s & poly)) ^ s[0];
        return (s >> 1) | (lfsr_wide_t'(fb) << (width - 1));
    endfunction

endpackage

// File: rtl/sync_descrambler_if.sv
// Bit-stream and status bundle between the receive link and the descrambler.
interface sync_descrambler_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             resync;
    logic             out_valid;
    logic             out_bit;
    logic             locked;
    logic [WIDTH-1:0] lfsr_state;

    modport master (
        output in_valid, in_bit, resync,
        input  out_valid, out_bit, locked, lfsr_state
    );

    modport slave (
        input  in_valid, in_bit, resync,
        output out_valid, out_bit, locked, lfsr_state
    );
endinterface

// File: rtl/lfsr_advance.sv
// Combinational jump of the LFSR state by STEPS single steps.
module lfsr_advance
    import sync_descrambler_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] POLYNOMIAL = 8'h71,
    parameter int unsigned      STEPS      = WIDTH
) (
    input  logic [WIDTH-1:0] s_i,
    output logic [WIDTH-1:0] s_o
);

    logic [WIDTH-1:0] s;

    always_comb begin
        s = s_i;
        for (int unsigned i = 0; i < STEPS; i++) begin
            s = WIDTH'(lfsr_next(lfsr_wide_t'(s), lfsr_wide_t'(POLYNOMIAL), WIDTH));
        end
        s_o = s;
    end

endmodule

// File: rtl/sync_descrambler.sv
// Self-synchronising descrambler: captures the keystream from idle traffic,
// verifies the prediction, then descrambles while watching for runs of 1s.
module sync_descrambler
    import sync_descrambler_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] POLYNOMIAL = 8'h71,
    parameter int unsigned      VERIFY_LEN = 16,
    parameter int unsigned      LOSS_RUN   = 32
) (
    input logic               clk,
    input logic               rst_n,
    sync_descrambler_if.slave bus
);

    localparam int unsigned BIT_CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned VER_CNT_W = $clog2(VERIFY_LEN + 1);
    localparam int unsigned RUN_CNT_W = $clog2(LOSS_RUN + 1);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WIDTH - 1);
    localparam logic [VER_CNT_W-1:0] VER_LAST = VER_CNT_W'(VERIFY_LEN - 1);
    localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(LOSS_RUN - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [WIDTH-2:0]     cap_q, cap_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [VER_CNT_W-1:0] ver_cnt_q, ver_cnt_d;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_bit_q, out_bit_d;
    logic                 locked_q, locked_d;

    logic [WIDTH-1:0]     cap_shift_c;
    logic [WIDTH-1:0]     lfsr_load_c;
    logic [WIDTH-1:0]     lfsr_step_c;
    logic                 descr_c;

    // C[0] is always shifted out by the time C is full, so only the upper bits are stored.
    assign cap_shift_c = {bus.in_bit, cap_q};
    assign lfsr_step_c = WIDTH'(lfsr_next(lfsr_wide_t'(lfsr_q), lfsr_wide_t'(POLYNOMIAL), WIDTH));
    assign descr_c     = bus.in_bit ^ lfsr_q[0];

    lfsr_advance #(
        .WIDTH      (WIDTH),
        .POLYNOMIAL (POLYNOMIAL),
        .STEPS      (WIDTH)
    ) u_lfsr_advance (
        .s_i (cap_shift_c),
        .s_o (lfsr_load_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEARCH;
            lfsr_q      <= '0;
            cap_q       <= '0;
            bit_cnt_q   <= '0;
            ver_cnt_q   <= '0;
            run_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cap_q       <= cap_d;
            bit_cnt_q   <= bit_cnt_d;
            ver_cnt_q   <= ver_cnt_d;
            run_cnt_q   <= run_cnt_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cap_d       = cap_q;
        bit_cnt_d   = bit_cnt_q;
        ver_cnt_d   = ver_cnt_q;
        run_cnt_d   = run_cnt_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;

        if (bus.resync) begin
            state_d   = ST_SEARCH;
            cap_d     = '0;
            bit_cnt_d = '0;
            ver_cnt_d = '0;
            run_cnt_d = '0;
        end else if (bus.in_valid) begin
            unique case (state_q)
                ST_SEARCH: begin
                    cap_d = cap_shift_c[WIDTH-1:1];
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (|cap_shift_c) begin
                            lfsr_d  = lfsr_load_c;
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
                ST_VERIFY: begin
                    if (bus.in_bit == lfsr_q[0]) begin
                        lfsr_d = lfsr_step_c;
                        if (ver_cnt_q == VER_LAST) begin
                            state_d = ST_LOCKED;
                        end else begin
                            ver_cnt_d = ver_cnt_q + VER_CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    out_valid_d = 1'b1;
                    out_bit_d   = descr_c;
                    lfsr_d      = lfsr_step_c;
                    if (!descr_c) begin
                        run_cnt_d = '0;
                    end else if (run_cnt_q == RUN_LAST) begin
                        state_d = ST_SEARCH;
                    end else begin
                        run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        // Every state change starts the counters afresh.
        if (state_d != state_q) begin
            bit_cnt_d = '0;
            ver_cnt_d = '0;
            run_cnt_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_bit    = out_bit_q;
    assign bus.locked     = locked_q;
    assign bus.lfsr_state = lfsr_q;

endmodule

// File: tb/tb_sync_descrambler.sv
// Scoreboard bench: a reference scrambler drives the link, expected plaintext is queued per bit.
module tb_sync_descrambler;

    logic clk;
    logic rst_n;

    sync_descrambler_if #(.WIDTH(8)) bus ();

    sync_descrambler #(
        .WIDTH      (8),
        .POLYNOMIAL (8'h71),
        .VERIFY_LEN (16),
        .LOSS_RUN   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_total;
    int         n_bad;
    bit         exp_valid_next;
    bit         sb_q[$];
    logic [7:0] tx_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tx_step(input logic [7:0] s);
        return {(^(s & 8'h71)) ^ s[0], s[7:1]};
    endfunction

    task automatic tick(input bit v, input bit b, input bit rs, input bit exp_out, input bit data);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.resync   = rs;
        @(posedge clk);
        if (exp_out) sb_q.push_back(data);
        exp_valid_next = exp_out;
        #1;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.resync   = 1'b0;
    endtask

    task automatic tx_send(input bit data, input bit exp_out);
        logic b;
        b    = data ^ tx_s[0];
        tx_s = tx_step(tx_s);
        tick(1'b1, b, 1'b0, exp_out, data);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) tx_send(d[i], 1'b1);
    endtask

    task automatic send_gappy(input int nbits);
        bit d;
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(0, 7)) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            d = (i % 16 == 15) ? 1'b0 : 1'($urandom_range(0, 1));
            tx_send(d, 1'b1);
        end
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.in_bit     = 1'b0;
        bus.resync     = 1'b0;
        exp_valid_next = 1'b0;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_bit", 32'(bus.out_bit), 32'd0);
        chk("rst_lfsr", 32'(bus.lfsr_state), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic relock(input string tag);
        for (int i = 1; i <= 24; i++) begin
            tx_send(1'b0, 1'b0);
            if (i == 8 || i == 23) chk({tag, "_early"}, 32'(bus.locked), 32'd0);
        end
        chk({tag, "_lock"}, 32'(bus.locked), 32'd1);
        chk({tag, "_lfsr"}, 32'(bus.lfsr_state), 32'(tx_s));
    endtask

    // Output monitor: valid must appear exactly one edge after a locked bit.
    always @(negedge clk) begin
        bit exp_b;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_valid_next));
        if (bus.out_valid === 1'b1) begin
            if (sb_q.size() != 0) begin
                exp_b = sb_q.pop_front();
                chk("out_bit", 32'(bus.out_bit), 32'(exp_b));
            end else begin
                chk("spurious_valid", 32'(bus.out_valid), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic b;
        n_total        = 0;
        n_bad          = 0;
        exp_valid_next = 1'b0;
        tx_s           = 8'hFF;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_bit     = 1'b0;
        bus.resync     = 1'b0;

        do_reset();

        // Unscrambled all-zero link must never leave SEARCH.
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("zero_locked", 32'(bus.locked), 32'd0);
        end
        chk("zero_lfsr", 32'(bus.lfsr_state), 32'd0);

        do_reset();
        tx_s = 8'hFF;
        relock("acq");
        send_byte(8'hA5);
        send_byte(8'h3C);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        send_gappy(48);

        // 32 consecutive descrambled 1s drop lock on the last one, which is still output.
        for (int i = 1; i <= 32; i++) begin
            tx_send(1'b1, 1'b1);
            if (i == 31) chk("loss_hold", 32'(bus.locked), 32'd1);
        end
        chk("loss_fall", 32'(bus.locked), 32'd0);
        relock("reloss");

        tx_send(1'b0, 1'b1);
        tx_send(1'b1, 1'b1);
        tick(1'b1, ~tx_s[0], 1'b1, 1'b0, 1'b0);
        chk("resync_locked", 32'(bus.locked), 32'd0);
        relock("resync");

        tx_send(1'b1, 1'b1);
        tx_send(1'b0, 1'b1);
        #2;
        do_reset();
        relock("rstpulse");
        send_byte(8'h96);

        // Non-trivial keystream; corrupt the 5th bit seen in VERIFY.
        do_reset();
        tx_s = 8'h5A;
        for (int i = 0; i < 12; i++) tx_send(1'b0, 1'b0);
        b    = ~tx_s[0];
        tx_s = tx_step(tx_s);
        tick(1'b1, b, 1'b0, 1'b0, 1'b0);
        chk("flip_locked", 32'(bus.locked), 32'd0);
        relock("flip");
        send_gappy(40);
        send_byte(8'hC3);

        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
